// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the RV32I integer register file:
//               enable levels, bus widths, register count, the pending-write
//               counter width and the read-port mux helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int REG_W          = 32;  // RegBus width
  localparam int REG_ADDR_W     = 5;   // RegAddrBus width
  localparam int REG_NUM        = 32;  // x0..x31
  localparam int PEND_W_DEFAULT = 2;   // pending-writer counter width

  typedef logic [REG_W-1:0]          reg_bus_t;
  typedef logic [REG_ADDR_W-1:0]     reg_addr_bus_t;
  typedef logic [PEND_W_DEFAULT-1:0] pend_bus_t;

  localparam reg_bus_t      ZERO_WORD    = '0;
  localparam reg_addr_bus_t NOP_REG_ADDR = '0;

  // Read-port priority: disabled port, then x0, then same-cycle write-back
  // bypass, then the stored value.
  function automatic reg_bus_t read_mux(
    input logic          re,
    input reg_addr_bus_t raddr,
    input logic          we,
    input reg_addr_bus_t waddr,
    input reg_bus_t      wdata,
    input reg_bus_t      stored
  );
    reg_bus_t d;
    d = ZERO_WORD;
    if ((re == ENABLE) && (raddr != NOP_REG_ADDR)) begin
      if ((we == ENABLE) && (waddr == raddr)) begin
        d = wdata;
      end else begin
        d = stored;
      end
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Pending-write scoreboard for the register file. One
//               saturating counter per register tracks issued-but-not-yet-
//               written-back instructions; produces the decode stall from the
//               per-port RAW hazard compares and the counter-full condition.
// Ports       : clk, rst            - clock, async active-high reset
//               re1_i/raddr1_i      - read port 1 request
//               re2_i/raddr2_i      - read port 2 request
//               we_i/waddr_i        - write-back (retires one writer)
//               issue_i/issue_we_i/issue_waddr_i - issue (adds one writer)
//               stallreq_o          - hold decode (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREG   = REG_NUM,
  parameter int PEND_W = PEND_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re1_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic                  re2_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic                  issue_i,
  input  logic                  issue_we_i,
  input  logic [REG_ADDR_W-1:0] issue_waddr_i,
  output logic                  stallreq_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];

  logic hz1;
  logic hz2;
  logic fullq;
  logic stall;
  logic accept;

  // A source is hazardous while any writer is in flight, except when the
  // only remaining writer lands this cycle: the bypass mux supplies its data.
  always_comb begin
    hz1 = (re1_i == ENABLE) && (raddr1_i != NOP_REG_ADDR) &&
          (pend_q[raddr1_i] != '0) &&
          !((we_i == ENABLE) && (waddr_i == raddr1_i) && (pend_q[raddr1_i] == PEND_ONE));
    hz2 = (re2_i == ENABLE) && (raddr2_i != NOP_REG_ADDR) &&
          (pend_q[raddr2_i] != '0) &&
          !((we_i == ENABLE) && (waddr_i == raddr2_i) && (pend_q[raddr2_i] == PEND_ONE));

    // A full counter can still take a new writer when one retires this cycle.
    fullq = (issue_i == ENABLE) && (issue_we_i == ENABLE) &&
            (issue_waddr_i != NOP_REG_ADDR) &&
            (pend_q[issue_waddr_i] == PEND_MAX) &&
            !((we_i == ENABLE) && (waddr_i == issue_waddr_i));

    stall  = !rst && (hz1 || hz2 || fullq);
    // A stalled issue never reaches the counters, so they cannot wrap.
    accept = (issue_i == ENABLE) && (issue_we_i == ENABLE) && !stall;
  end

  assign stallreq_o = stall;

  always_comb begin
    logic inc;
    logic dec;
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      inc = accept && (issue_waddr_i == REG_ADDR_W'(r));
      dec = (we_i == ENABLE) && (waddr_i == REG_ADDR_W'(r));
      if (r == 0) begin
        pend_d[r] = '0;
      end else if (inc && !dec) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (dec && !inc && (pend_q[r] != '0)) begin
        // Retiring with nothing pending is a protocol error; hold at zero.
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : RV32I integer register file x0..x31 with one write-back port,
//               two combinational read ports with same-cycle write bypass,
//               and a pending-write scoreboard driving the decode stall.
// Ports       : clk, rst            - clock, async active-high reset
//               re1_i/raddr1_i/rdata1_o - read port 1
//               re2_i/raddr2_i/rdata2_o - read port 2
//               we_i/waddr_i/wdata_i    - write-back
//               issue_i/issue_we_i/issue_waddr_i - decode issue
//               stallreq_o          - hold decode (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
  import regfile_pkg::*;
#(
  parameter int NREG   = REG_NUM,
  parameter int PEND_W = PEND_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re1_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic                  re2_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [REG_W-1:0]      rdata1_o,
  output logic [REG_W-1:0]      rdata2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [REG_W-1:0]      wdata_i,
  input  logic                  issue_i,
  input  logic                  issue_we_i,
  input  logic [REG_ADDR_W-1:0] issue_waddr_i,
  output logic                  stallreq_o
);

  logic [REG_W-1:0] regs_q [NREG];
  logic [REG_W-1:0] regs_d [NREG];

  // Storage update; x0 is forced to zero so it never holds written data.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
    end
    if ((we_i == ENABLE) && (waddr_i != NOP_REG_ADDR)) begin
      regs_d[waddr_i] = wdata_i;
    end
    regs_d[0] = ZERO_WORD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= ZERO_WORD;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // Reads are forced to zero while reset is held so a write-back presented
  // during reset cannot leak through the bypass path.
  always_comb begin
    rdata1_o = ZERO_WORD;
    rdata2_o = ZERO_WORD;
    if (!rst) begin
      rdata1_o = read_mux(re1_i, raddr1_i, we_i, waddr_i, wdata_i, regs_q[raddr1_i]);
      rdata2_o = read_mux(re2_i, raddr2_i, we_i, waddr_i, wdata_i, regs_q[raddr2_i]);
    end
  end

  regfile_sb #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .re1_i         (re1_i),
    .raddr1_i      (raddr1_i),
    .re2_i         (re2_i),
    .raddr2_i      (raddr2_i),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .issue_i       (issue_i),
    .issue_we_i    (issue_we_i),
    .issue_waddr_i (issue_waddr_i),
    .stallreq_o    (stallreq_o)
  );

endmodule
`default_nettype wire
